// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the master FSM state type.
//   HTRANS_*      : transfer-type encodings used by the master (IDLE, NONSEQ)
//   HSIZE_WORD    : 32-bit transfer size
//   HBURST_SINGLE : single-beat burst encoding
//   HRESP_*       : slave response encodings
//   ahb_state_e   : master FSM states
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } ahb_state_e;

  // Word transfers need the two byte-lane bits of the address clear.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ahb_master.sv
// ahb_master: single-outstanding AHB-Lite master. Turns one valid/ready word request into one
// NONSEQ/SINGLE transfer and returns a one-cycle response pulse.
// Ports:
//   HCLK, HRESET                 : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only while idle)
//   req_write/req_addr/req_wdata : request payload, sampled on the accept edge
//   rsp_valid/rsp_rdata/rsp_error: one-cycle response; rdata holds between responses
//   HADDR..HWDATA                : registered AHB-Lite master outputs
//   HRDATA/HREADY/HRESP          : AHB-Lite slave return signals
module ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  ahb_state_e state_q, state_d;

  // Request latch: haddr_q/hwrite_q double as the latched address and direction, since the bus
  // must hold them through the data phase anyway. wdata is held until the data phase starts.
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (!is_word_aligned(req_addr[1:0])) begin
            // Reject without touching the bus; answer in the very next cycle.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d  = StAddr;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = req_addr;
            hwrite_d = req_write;
          end
        end
      end

      StAddr: begin
        if (HREADY) begin
          state_d  = StData;
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end

      StData: begin
        // First cycle of a two-cycle ERROR has HREADY low and is just another wait state.
        if (HREADY) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_error_d = (HRESP == HRESP_ERROR);
          if (!hwrite_q) begin
            rsp_rdata_d = HRDATA;
          end
        end
      end

      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
        htrans_d    = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= StIdle;
      wdata_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;

  // Handshake and bus-encoding invariants.
  a_no_ready_with_rsp : assert property (@(posedge HCLK) disable iff (HRESET)
    !(req_ready && rsp_valid));
  a_legal_htrans : assert property (@(posedge HCLK) disable iff (HRESET)
    (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ));

endmodule

// File: doc/ahb_master.md
# ahb_master

Single-outstanding AHB-Lite bus master for the edge-detection accelerator. The datapath uses it to fetch source pixels from system memory at `source_addr` and to store results at `dest_addr`. It is the initiator counterpart of the accelerator's AHB slave configuration port. It converts a simple valid/ready word request into one NONSEQ/SINGLE AHB transfer and returns a one-cycle response pulse carrying read data or an error flag.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width (word transfers only)

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge
- HRESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; must be word aligned
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads
- rsp_error  out  1  transfer failed; valid with rsp_valid
- HADDR  out  ADDR_W  bus address
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only
- HWRITE  out  1  bus direction
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWDATA  out  DATA_W  write data, driven in the data phase
- HRDATA  in  DATA_W  read data
- HREADY  in  1  transfer-done / address-accept
- HRESP  in  1  0 = OKAY, 1 = ERROR

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - req_ready = 1 and HTRANS = IDLE.
  - On req_valid: latch addr, write and wdata.
  - If req_addr[1:0] != 0 → go to RESP with err = 1; no bus transfer is issued.
  - Otherwise → go to ADDR.
- **ADDR**
  - Drive HTRANS = NONSEQ, HADDR = latched addr, HWRITE = latched write.
  - Stay while HREADY = 0; on HREADY = 1 → DATA.
- **DATA**
  - Drive HTRANS = IDLE and HWDATA = latched wdata. HADDR and HWRITE hold their values.
  - Stay while HREADY = 0.
  - On HREADY = 1: capture HRDATA (reads only) and err = HRESP → RESP.
  - The HRESP = ERROR first cycle with HREADY = 0 is treated as a wait state.
- **RESP**
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_error.
  - → IDLE. req_ready stays 0 in this cycle.
- rsp_rdata holds its last captured value between responses. It is unchanged by writes and by misaligned rejects.
- All bus outputs are registered. No combinational path exists from HREADY/HRESP to any output.
- HRESET overrides all state, including mid-transfer. The next cycle is IDLE with bus outputs at reset values. The aborted request is dropped with no rsp_valid.

## Timing
Reset values:
- req_ready = 1
- rsp_valid = 0, rsp_rdata = 0, rsp_error = 0
- HADDR = 0, HTRANS = 2'b00, HWRITE = 0, HWDATA = 0
- HSIZE = 3'b010, HBURST = 3'b000

Latency:
- With zero wait states, a request accepted at edge E0 gives HTRANS = NONSEQ in cycle E0→E1, the data phase in E1→E2, and rsp_valid in E2→E3.
- Each HREADY = 0 cycle in ADDR or DATA adds one cycle.
- Misaligned request: rsp_valid with rsp_error = 1 in the cycle after acceptance.

Throughput and handshake:
- Maximum throughput is one transfer per 4 cycles; back-to-back requests are accepted in the cycle after RESP.
- req_* is sampled only on the accept edge. Later changes to req_* have no effect on the transfer in flight.
- req_ready and rsp_valid are never high in the same cycle.

## Structure
- Package ahb_pkg holds:
  - htrans constants (HTRANS_IDLE, HTRANS_NONSEQ)
  - HSIZE_WORD and HBURST_SINGLE
  - HRESP_OKAY and HRESP_ERROR
  - the state enum typedef
- One flat module with a single FSM plus a latch register set; no sub-module.

## Test plan
- **Zero-wait read:** req addr 0x0000_1000, HRDATA = 0xDEAD_BEEF, HREADY = 1 → NONSEQ for one cycle with HADDR = 0x1000 and HWRITE = 0; rsp_valid 3 cycles after acceptance with rsp_rdata = 0xDEAD_BEEF and rsp_error = 0.
- **Wait-stated write:** req addr 0x2004, wdata 0x0000_00FF; HREADY low 1 cycle in ADDR and 2 cycles in DATA → HWDATA = 0xFF held through all of DATA; rsp_valid at cycle 6 after acceptance; rsp_rdata unchanged.
- **Error response:** read with a two-cycle HRESP = ERROR (HREADY 0 then 1) → rsp_valid with rsp_error = 1; HTRANS stays IDLE afterwards.
- **Misaligned request:** req addr 0x3002 → HTRANS never NONSEQ; rsp_valid with rsp_error = 1 one cycle after acceptance.
- **Reset mid-transfer:** HRESET asserted during DATA with HREADY = 0 → next cycle HTRANS = 0, req_ready = 1, and no rsp_valid ever issued for that request.
- **Back-to-back:** req_valid held high with 3 distinct reads → exactly 3 responses in order, 4 cycles apart, with req_ready low from acceptance through RESP.
